// File: rtl/tf_rom_arbiter_pkg.sv
// Shared types and constants for the twiddle-factor ROM arbiter.
// Requester indices match the NTT/INTT address generators of one path.
package tf_rom_arbiter_pkg;

    localparam int TF_REQ_NTT  = 0;
    localparam int TF_REQ_INTT = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    // A single requester still needs a one-bit ID field.
    function automatic int tf_id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/tf_rom_tag_pipe.sv
// Shift register of {vld, id} that tracks ROM reads until their data
// emerges. Only the valid bits are reset; IDs are ignored while vld=0.
module tf_rom_tag_pipe #(
    parameter int DEPTH    = 2,
    parameter int ID_WIDTH = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_vld,
    input  logic [ID_WIDTH-1:0] in_id,
    output logic                out_vld,
    output logic [ID_WIDTH-1:0] out_id
);

    logic [DEPTH-1:0]               vld_pipe;
    logic [DEPTH-1:0][ID_WIDTH-1:0] id_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= in_vld;
            for (int s = 1; s < DEPTH; s++) vld_pipe[s] <= vld_pipe[s-1];
        end
    end

    always_ff @(posedge clk) begin
        id_pipe[0] <= in_id;
        for (int s = 1; s < DEPTH; s++) id_pipe[s] <= id_pipe[s-1];
    end

    assign out_vld = vld_pipe[DEPTH-1];
    assign out_id  = id_pipe[DEPTH-1];

endmodule

// File: rtl/tf_rom_arbiter.sv
// Round-robin arbiter with burst locking in front of one twiddle ROM;
// returns each read word with a one-hot strobe to its issuing requester.
module tf_rom_arbiter
    import tf_rom_arbiter_pkg::*;
#(
    parameter int NUM_REQ           = 2,
    parameter int ADDR_WIDTH        = 11,
    parameter int COE_WIDTH         = 39,
    parameter int COMMON_BRAM_DELAY = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [COE_WIDTH-1:0]          rom_data,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [COE_WIDTH-1:0]          rsp_data
);

    localparam int ID_W = tf_id_width(NUM_REQ);

    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_arr;
    arb_state_e                         state;
    logic [ID_W-1:0]                    owner;
    logic [ID_W-1:0]                    rr_ptr;
    logic [ID_W-1:0]                    grant_id;
    logic                               grant_any;
    logic                               tag_vld;
    logic [ID_W-1:0]                    tag_id;

    assign addr_arr = req_addr;

    // Descending scan so the requester closest to rr_ptr wins the overwrite.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_id  = '0;
        if (!rst) begin
            if (state == ST_LOCK) begin
                grant_any = req_valid[owner];
                grant_id  = owner;
            end else begin
                for (int k = NUM_REQ - 1; k >= 0; k--) begin
                    idx = int'(rr_ptr) + k;
                    if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                    if (req_valid[idx[ID_W-1:0]]) begin
                        grant_any = 1'b1;
                        grant_id  = idx[ID_W-1:0];
                    end
                end
            end
        end
    end

    assign req_ready = grant_any ? (NUM_REQ'(1) << grant_id) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            rom_addr <= '0;
        end else if (grant_any) begin
            rom_addr <= addr_arr[grant_id];
            if (req_last[grant_id]) begin
                state  <= ST_IDLE;
                rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
            end else begin
                state <= ST_LOCK;
                owner <= grant_id;
            end
        end
    end

    // One stage for the rom_addr register plus one per ROM latency cycle.
    tf_rom_tag_pipe #(
        .DEPTH   (COMMON_BRAM_DELAY + 1),
        .ID_WIDTH(ID_W)
    ) u_tag_pipe (
        .clk    (clk),
        .rst    (rst),
        .in_vld (grant_any),
        .in_id  (grant_id),
        .out_vld(tag_vld),
        .out_id (tag_id)
    );

    assign rsp_valid = tag_vld ? (NUM_REQ'(1) << tag_id) : '0;
    assign rsp_data  = rom_data;

endmodule
